fifo_move_reader: RTL

Consumer side of the move FIFO. It pops 2-bit cube-move codes from the FIFO read port and turns each code into a burst of stepper STEP/DIR pulses. After each move it holds a settle time before the next pop. It sits between the FIFO read port (rd, dout, empty) and the stepper driver pins.

---
 rtl/fifo_move_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_move_reader.sv
// fifo_move_reader: consumer side of the move FIFO. It pops one 2-bit cube-move
// code at a time and plays it out as a burst of STEP pulses with a fixed DIR,
// followed by a settle gap before the next pop.
// Optional build macro: MOVE_CNT_EN adds a wrapping count of completed moves
// on move_cnt. Without it, move_cnt is constant zero.
//
// state   | meaning
// IDLE    | waiting for enable=1 with a non-empty FIFO
// READ    | one-cycle rd strobe to the FIFO
// LATCH   | din valid; decode code, load dir and pulse count
// STEP_HI | STEP high phase of one pulse
// STEP_LO | STEP low phase; after the last pulse go to SETTLE
// SETTLE  | post-move settle gap, done pulses on exit
module fifo_move_reader #(
    parameter int DW       = 2,
    parameter int STEPS_Q  = 50,
    parameter int PULSE_HI = 4,
    parameter int PULSE_LO = 4,
    parameter int SETTLE   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          empty,
    input  logic [DW-1:0] din,
    output logic          rd,
    output logic          step,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic [7:0]    move_cnt
);

    localparam int TMAX_HL = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int TMAX    = (TMAX_HL > SETTLE) ? TMAX_HL : SETTLE;
    localparam int RW      = $clog2(2 * STEPS_Q + 1);
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_STEP_HI = 3'd3;
    localparam logic [2:0] S_STEP_LO = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;

    // Timers are down-counters loaded with length-1; a phase ends at zero.
    localparam logic [TW-1:0] T_HI     = TW'(PULSE_HI - 1);
    localparam logic [TW-1:0] T_LO     = TW'(PULSE_LO - 1);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE - 1);
    localparam logic [RW-1:0] N_QUART  = RW'(STEPS_Q);
    localparam logic [RW-1:0] N_HALF   = RW'(2 * STEPS_Q);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] remaining_q, remaining_d;
    logic          dir_q, dir_d;
    logic          rd_q, rd_d;
    logic          step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, timer and pulse-count logic for the move sequencer.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !empty) state_d = S_READ;
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                timer_d = T_HI;
                state_d = S_STEP_HI;
                case (din[1:0])
                    2'b01: begin
                        dir_d       = 1'b1;
                        remaining_d = N_QUART;
                    end
                    2'b10: begin
                        dir_d       = 1'b0;
                        remaining_d = N_QUART;
                    end
                    2'b11: begin
                        dir_d       = 1'b1;
                        remaining_d = N_HALF;
                    end
                    default: begin
                        // no-op move: complete immediately, dir untouched
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
            S_STEP_HI: begin
                if (timer_q == '0) begin
                    timer_d = T_LO;
                    state_d = S_STEP_LO;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STEP_LO: begin
                if (timer_q == '0) begin
                    remaining_d = remaining_q - RW'(1);
                    if (remaining_q == RW'(1)) begin
                        timer_d = T_SETTLE;
                        state_d = S_SETTLE;
                    end else begin
                        timer_d = T_HI;
                        state_d = S_STEP_HI;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop.
    always_comb begin
        rd_d   = (state_d == S_READ);
        step_d = (state_d == S_STEP_HI);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any move in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            rd_q        <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            rd_q        <= rd_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd   = rd_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef MOVE_CNT_EN
    logic [7:0] move_cnt_q, move_cnt_d;

    // Completed-move count, advancing with each done pulse and wrapping at 8 bits.
    always_comb begin
        move_cnt_d = move_cnt_q;
        if (done_d) move_cnt_d = move_cnt_q + 8'd1;
    end

    // Move counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) move_cnt_q <= 8'd0;
        else       move_cnt_q <= move_cnt_d;
    end

    assign move_cnt = move_cnt_q;
`else
    assign move_cnt = 8'd0;
`endif

endmodule
